instr_read_issuer: RTL and testbench

- Consumer end of the instruction-read queue.
- Pops InstructionRead descriptors from the instruction-read FIFO: standard read mode, dout valid one cycle after rd_en.
- Splits each descriptor into bounded memory read bursts and presents them on a valid/ready request interface to the memory read port.
- Sits between the instruction-read FIFO and the DMA/memory read engine.

---
 rtl/definitions_pkg.sv | 20 ++
 rtl/instr_read_issuer.sv | 127 ++++++++++++
 tb/tb_instr_read_issuer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// Shared types for the instruction-read path: the queued descriptor format
// and the issuer state encoding.
package definitions_pkg;

    localparam int DESC_ADDR_W = 32;
    localparam int DESC_LEN_W  = 16;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_LEN_W-1:0]  len;
    } InstructionRead;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOAD,
        ISSUE
    } issuer_state_e;

endpackage

// File: rtl/instr_read_issuer.sv
// Pops InstructionRead descriptors from the instruction-read FIFO and splits
// each one into bounded memory read bursts on a valid/ready request port.
module instr_read_issuer
    import definitions_pkg::*;
#(
    parameter int ADDR_W      = DESC_ADDR_W,
    parameter int LEN_W       = DESC_LEN_W,
    parameter int MAX_BURST   = 16,
    parameter int WORD_BYTES  = 4,
    parameter int INPUT_WIDTH = $bits(InstructionRead)
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [INPUT_WIDTH-1:0]       fifo_dout,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [ADDR_W-1:0]            req_addr,
    output logic [$clog2(MAX_BURST):0]   req_len,
    output logic                         req_last,
    output logic                         desc_done,
    output logic                         busy
);

    localparam int REQ_LEN_W = $clog2(MAX_BURST) + 1;

    issuer_state_e          state, state_d;
    logic [LEN_W-1:0]       remaining, remaining_d;
    logic [ADDR_W-1:0]      req_addr_d;
    logic [REQ_LEN_W-1:0]   req_len_d;
    logic                   req_last_d;

    logic [ADDR_W-1:0]      load_addr, next_addr;
    logic [LEN_W-1:0]       load_len, next_remaining;
    logic [REQ_LEN_W:0]     burst;

    // Returns {last, len} for a burst cut from the words still outstanding.
    function automatic logic [REQ_LEN_W:0] next_burst(input logic [LEN_W-1:0] rem);
        if (rem <= LEN_W'(MAX_BURST))
            return {1'b1, REQ_LEN_W'(rem)};
        return {1'b0, REQ_LEN_W'(MAX_BURST)};
    endfunction

    assign load_addr      = fifo_dout[ADDR_W+LEN_W-1 -: ADDR_W];
    assign load_len       = fifo_dout[LEN_W-1:0];
    assign next_addr      = req_addr + ADDR_W'(req_len) * ADDR_W'(WORD_BYTES);
    assign next_remaining = remaining - LEN_W'(req_len);

    assign req_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        req_addr_d  = req_addr;
        req_len_d   = req_len;
        req_last_d  = req_last;
        fifo_rd_en  = 1'b0;
        desc_done   = 1'b0;
        burst       = '0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: state_d = LOAD;
            LOAD: begin
                // The FIFO holds dout until the next pop, so it is still valid here.
                if (load_len == '0) begin
                    desc_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    burst       = next_burst(load_len);
                    remaining_d = load_len;
                    req_addr_d  = load_addr;
                    req_len_d   = burst[REQ_LEN_W-1:0];
                    req_last_d  = burst[REQ_LEN_W];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    remaining_d = next_remaining;
                    if (req_last) begin
                        desc_done  = 1'b1;
                        req_addr_d = '0;
                        req_len_d  = '0;
                        req_last_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        burst      = next_burst(next_remaining);
                        req_addr_d = next_addr;
                        req_len_d  = burst[REQ_LEN_W-1:0];
                        req_last_d = burst[REQ_LEN_W];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (srst) begin
            fifo_rd_en = 1'b0;
            desc_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            remaining <= '0;
            req_addr  <= '0;
            req_len   <= '0;
            req_last  <= 1'b0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            req_addr  <= req_addr_d;
            req_len   <= req_len_d;
            req_last  <= req_last_d;
        end
    end

endmodule

// File: tb/tb_instr_read_issuer.sv
// Scoreboard bench for instr_read_issuer: a FIFO model feeds descriptors and
// expected bursts are queued when each descriptor is pushed.
module tb_instr_read_issuer;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [47:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic [4:0]  req_len;
    logic        req_last;
    logic        desc_done;
    logic        busy;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  len;
        logic        last;
    } burst_t;

    logic [47:0] fifo_q[$];
    burst_t      exp_q[$];
    int          push_cnt = 0;
    int          pop_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    instr_read_issuer dut (
        .clk        (clk),
        .srst       (srst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_last   (req_last),
        .desc_done  (desc_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    // Standard-mode FIFO: dout updates on the edge that sees rd_en.
    always @(posedge clk) begin
        if (srst) begin
            fifo_q.delete();
            pop_cnt <= push_cnt;
        end else if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_dout <= fifo_q.pop_front();
            pop_cnt   <= pop_cnt + 1;
        end
    end

    task automatic push_desc(input logic [31:0] a, input logic [15:0] l);
        logic [31:0] addr = a;
        int          rem = int'(l);
        int          n;
        fifo_q.push_back({a, l});
        push_cnt++;
        while (rem > 0) begin
            n = (rem > 16) ? 16 : rem;
            exp_q.push_back({addr, 5'(n), rem <= 16});
            addr = addr + 32'(n * 4);
            rem  = rem - n;
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        req_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({fifo_rd_en, req_valid, req_addr, req_len, req_last, desc_done, busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got rd=%b v=%b a=%h l=%0d last=%b done=%b busy=%b, expected all zero",
                     fifo_rd_en, req_valid, req_addr, req_len, req_last, desc_done, busy);
        end
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || req_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got busy=%b valid=%b, expected 0/0", busy, req_valid);
        end
    endtask

    task automatic test_single();
        int     pops = 0;
        int     dones = 0;
        burst_t got, exp;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            req_ready = 1'b1;
            if (c == 0) push_desc(32'h0000_1000, 16'd40);
            @(negedge clk);
            if (fifo_rd_en) pops++;
            if (desc_done) dones++;
            if (req_valid && req_ready) begin
                got = {req_addr, req_len, req_last};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL single_extra: got burst %h/%0d/%0b, expected none", got.addr, got.len, got.last);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL single_burst: got %h/%0d/%0b, expected %h/%0d/%0b",
                                 got.addr, got.len, got.last, exp.addr, exp.len, exp.last);
                    end
                    n_cmp++;
                    if (desc_done !== exp.last) begin
                        n_fail++;
                        $display("[TB] FAIL single_done_timing: got %b, expected %b", desc_done, exp.last);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL single_left: got %0d bursts outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (pops !== 1) begin
            n_fail++;
            $display("[TB] FAIL single_pops: got %0d, expected 1", pops);
        end
        n_cmp++;
        if (dones !== 1) begin
            n_fail++;
            $display("[TB] FAIL single_dones: got %0d, expected 1", dones);
        end
    endtask

    task automatic test_zero_len();
        int rd_cyc = -100;
        int done_cyc = -1;
        int valids = 0;
        int dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            req_ready = 1'b1;
            if (c == 0) push_desc(32'h0000_8000, 16'd0);
            @(negedge clk);
            if (fifo_rd_en) rd_cyc = c;
            if (desc_done) begin
                done_cyc = c;
                dones++;
            end
            if (req_valid) valids++;
        end
        n_cmp++;
        if (done_cyc - rd_cyc !== 2) begin
            n_fail++;
            $display("[TB] FAIL zero_done_delay: got %0d cycles, expected 2", done_cyc - rd_cyc);
        end
        n_cmp++;
        if (valids !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero_no_request: got %0d valid cycles, expected 0", valids);
        end
        n_cmp++;
        if (dones !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_done_idle: got dones=%0d busy=%b, expected 1/0", dones, busy);
        end
    endtask

    task automatic test_backpressure();
        int     pops = 0;
        int     dones = 0;
        int     stalls = 0;
        int     stall_left = 0;
        burst_t got, exp;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                req_ready = 1'b0;
                stall_left--;
            end else begin
                req_ready = 1'b1;
            end
            if (c == 0) push_desc(32'h0000_2000, 16'd32);
            @(negedge clk);
            if (fifo_rd_en) pops++;
            if (desc_done) dones++;
            got = {req_addr, req_len, req_last};
            if (req_valid && !req_ready && exp_q.size() != 0) begin
                stalls++;
                n_cmp++;
                if (got !== exp_q[0]) begin
                    n_fail++;
                    $display("[TB] FAIL bp_hold: got %h/%0d/%0b, expected %h/%0d/%0b",
                             got.addr, got.len, got.last, exp_q[0].addr, exp_q[0].len, exp_q[0].last);
                end
            end
            if (req_valid && req_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL bp_extra: got burst %h/%0d/%0b, expected none", got.addr, got.len, got.last);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL bp_burst: got %h/%0d/%0b, expected %h/%0d/%0b",
                                 got.addr, got.len, got.last, exp.addr, exp.len, exp.last);
                    end
                    if (got.addr == 32'h0000_2000) stall_left = 5;
                end
            end
        end
        n_cmp++;
        if (stalls !== 5) begin
            n_fail++;
            $display("[TB] FAIL bp_stall_cycles: got %0d, expected 5", stalls);
        end
        n_cmp++;
        if (exp_q.size() != 0 || pops !== 1 || dones !== 1) begin
            n_fail++;
            $display("[TB] FAIL bp_complete: got left=%0d pops=%0d dones=%0d, expected 0/1/1", exp_q.size(), pops, dones);
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int     pops = 0;
        int     dones = 0;
        int     bad_rd = 0;
        int     last_done = -1;
        logic   prev_valid = 1'b0;
        burst_t got, exp;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            req_ready = 1'b1;
            if (c == 0) begin
                push_desc(32'h0000_5000, 16'd1);
                push_desc(32'h0000_6000, 16'd17);
                push_desc(32'h0000_7000, 16'd16);
            end
            @(negedge clk);
            if (fifo_rd_en) pops++;
            if (fifo_rd_en && (fifo_empty || busy)) bad_rd++;
            if (req_valid && !prev_valid && last_done >= 0) begin
                n_cmp++;
                if (c - last_done !== 4) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_gap: got %0d cycles done-to-request, expected 4", c - last_done);
                end
            end
            prev_valid = req_valid;
            if (desc_done) begin
                dones++;
                last_done = c;
            end
            if (req_valid && req_ready) begin
                got = {req_addr, req_len, req_last};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_extra: got burst %h/%0d/%0b, expected none", got.addr, got.len, got.last);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_burst: got %h/%0d/%0b, expected %h/%0d/%0b",
                                 got.addr, got.len, got.last, exp.addr, exp.len, exp.last);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || pops !== 3 || dones !== 3) begin
            n_fail++;
            $display("[TB] FAIL b2b_complete: got left=%0d pops=%0d dones=%0d, expected 0/3/3", exp_q.size(), pops, dones);
            exp_q.delete();
        end
        n_cmp++;
        if (bad_rd !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_pop_rule: got %0d illegal pops, expected 0", bad_rd);
        end
    endtask

    task automatic test_addr_wrap();
        int     dones = 0;
        burst_t got, exp;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            req_ready = 1'b1;
            if (c == 0) begin
                push_desc(32'hFFFF_FFF0, 16'd8);
                push_desc(32'hFFFF_FFF0, 16'd20);
            end
            @(negedge clk);
            if (desc_done) dones++;
            if (req_valid && req_ready) begin
                got = {req_addr, req_len, req_last};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_extra: got burst %h/%0d/%0b, expected none", got.addr, got.len, got.last);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL wrap_burst: got %h/%0d/%0b, expected %h/%0d/%0b",
                                 got.addr, got.len, got.last, exp.addr, exp.len, exp.last);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || dones !== 2) begin
            n_fail++;
            $display("[TB] FAIL wrap_complete: got left=%0d dones=%0d, expected 0/2", exp_q.size(), dones);
            exp_q.delete();
        end
    endtask

    task automatic test_srst();
        logic   seen = 1'b0;
        int     dones = 0;
        burst_t got, exp;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            req_ready = 1'b0;
            if (c == 0) push_desc(32'h0000_3000, 16'd64);
            @(negedge clk);
            if (req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("[TB] FAIL srst_reach_issue: got no request within 20 cycles, expected one");
        end
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({fifo_rd_en, req_valid, req_addr, req_len, req_last, desc_done, busy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL srst_outputs: got rd=%b v=%b a=%h l=%0d last=%b done=%b busy=%b, expected all zero",
                     fifo_rd_en, req_valid, req_addr, req_len, req_last, desc_done, busy);
        end
        @(posedge clk); #1;
        srst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            req_ready = 1'b1;
            if (c == 0) push_desc(32'h0000_4000, 16'd5);
            @(negedge clk);
            if (desc_done) dones++;
            if (req_valid && req_ready) begin
                got = {req_addr, req_len, req_last};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL srst_extra: got burst %h/%0d/%0b, expected none", got.addr, got.len, got.last);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL srst_resume_burst: got %h/%0d/%0b, expected %h/%0d/%0b",
                                 got.addr, got.len, got.last, exp.addr, exp.len, exp.last);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || dones !== 1) begin
            n_fail++;
            $display("[TB] FAIL srst_resume_complete: got left=%0d dones=%0d, expected 0/1", exp_q.size(), dones);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_backpressure();
        test_back_to_back();
        test_addr_wrap();
        test_srst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
